// File: rtl/mlp_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_layer_sequencer
//
// Sequences a two-layer fully connected network over an external multiplier.
// For each output neuron it walks the input vector, presenting an input/hidden
// RAM address and a weight RAM address every cycle. It accumulates the products
// that come back one cycle later, then writes the neuron result. Layer-0 results
// pass through ReLU into the hidden RAM and become the inputs of layer 1. Layer-1
// results are written unmodified to the result RAM.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   start     : run request, sampled only while idle
//   psum      : signed product from the external multiplier
//   layer     : 0 = input RAM feeds the multiplier, 1 = hidden RAM feeds it
//   in_addr   : input/hidden RAM read address
//   w_addr    : weight RAM read address (registered)
//   out_addr  : index of the neuron being computed and written
//   out_we    : write strobe for out_data at out_addr
//   out_data  : neuron result (ReLU applied in layer 0)
//   busy      : high whenever the sequencer is not idle
//   done      : one-cycle pulse at the end of a run
//
// psum timing contract: psum carries the product of the addresses presented in
// the previous cycle. The internal valid flag is state==ISSUE delayed by one
// cycle, so psum is summed exactly on those edges and ignored on all others.
// There is no back-pressure; the multiplier must keep up every cycle.
// -----------------------------------------------------------------------------
module mlp_layer_sequencer #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int WADDR_W = 8,
   parameter int L0_IN   = 13,
   parameter int L0_OUT  = 6,
   parameter int L1_OUT  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DATA_W-1:0]  psum,
   output logic               layer,
   output logic [ADDR_W-1:0]  in_addr,
   output logic [WADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0]  out_addr,
   output logic               out_we,
   output logic [DATA_W-1:0]  out_data,
   output logic               busy,
   output logic               done
);

   localparam logic [ADDR_W-1:0]  L0_IN_A  = ADDR_W'(L0_IN);
   localparam logic [ADDR_W-1:0]  L0_OUT_A = ADDR_W'(L0_OUT);
   localparam logic [ADDR_W-1:0]  L1_OUT_A = ADDR_W'(L1_OUT);
   localparam logic [WADDR_W-1:0] L0_IN_W  = WADDR_W'(L0_IN);
   localparam logic [WADDR_W-1:0] L0_OUT_W = WADDR_W'(L0_OUT);
   // Layer-1 weights are stored directly after the layer-0 weight block.
   localparam logic [WADDR_W-1:0] L1_BASE  = WADDR_W'(L0_IN * L0_OUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_DRAIN = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state;
   state_t             state_n;
   logic               layer_n;
   logic [ADDR_W-1:0]  in_n;
   logic [ADDR_W-1:0]  out_n;
   logic               acc_clr;
   logic               valid;
   logic [DATA_W-1:0]  acc;
   logic [ADDR_W-1:0]  n_in;
   logic [ADDR_W-1:0]  n_out;
   logic [WADDR_W-1:0] w_base_n;
   logic [WADDR_W-1:0] w_step_n;
   logic [WADDR_W-1:0] w_addr_n;

   // Input count and neuron count of the layer currently being processed.
   assign n_in  = layer ? L0_OUT_A : L0_IN_A;
   assign n_out = layer ? L1_OUT_A : L0_OUT_A;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and next-address logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_n = state;
      layer_n = layer;
      in_n    = in_addr;
      out_n   = out_addr;
      acc_clr = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_ISSUE;
               layer_n = 1'b0;
               in_n    = '0;
               out_n   = '0;
               acc_clr = 1'b1;
            end
         end
         S_ISSUE: begin
            // in_addr parks on the last input while the final product drains.
            if (in_addr == n_in - 1'b1) begin
               state_n = S_DRAIN;
            end else begin
               in_n = in_addr + 1'b1;
            end
         end
         S_DRAIN: begin
            state_n = S_WRITE;
         end
         S_WRITE: begin
            acc_clr = 1'b1;
            in_n    = '0;
            if (out_addr != n_out - 1'b1) begin
               out_n   = out_addr + 1'b1;
               state_n = S_ISSUE;
            end else if (!layer) begin
               out_n   = '0;
               layer_n = 1'b1;
               state_n = S_ISSUE;
            end else begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // The weight address is computed from the next-cycle indices so the
   // registered w_addr always matches the in_addr/out_addr/layer it sits beside.
   always_comb begin
      w_base_n = layer_n ? L1_BASE : '0;
      w_step_n = layer_n ? L0_OUT_W : L0_IN_W;
      w_addr_n = w_base_n + WADDR_W'(out_n) * w_step_n + WADDR_W'(in_n);
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         layer    <= 1'b0;
         in_addr  <= '0;
         out_addr <= '0;
         w_addr   <= '0;
         valid    <= 1'b0;
         acc      <= '0;
      end else begin
         layer    <= layer_n;
         in_addr  <= in_n;
         out_addr <= out_n;
         w_addr   <= w_addr_n;
         valid    <= (state == S_ISSUE);
         if (acc_clr) begin
            acc <= '0;
         end else if (valid) begin
            // Plain modulo-2^DATA_W wrap, no saturation.
            acc <= acc + psum;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign out_we = (state == S_WRITE);
   assign busy   = (state != S_IDLE);
   assign done   = (state == S_DONE);

   // ReLU on layer 0 only; the output bus is held at zero outside WRITE.
   assign out_data = !out_we                  ? '0 :
                     (!layer && acc[DATA_W-1]) ? '0 : acc;

endmodule

// File: doc/mlp_layer_sequencer.md
MLP_LAYER_SEQUENCER -- requirements
Module: mlp_layer_sequencer

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- DATA_W, 16, psum/accumulator/output data width.
- ADDR_W, 4, in_addr/out_addr width.
- WADDR_W, 8, w_addr width.
- L0_IN, 13, layer-0 input count.
- L0_OUT, 6, layer-0 output count; also the layer-1 input count.
- L1_OUT, 3, layer-1 output count.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- start, in, 1, run request; sampled only in IDLE.
- psum, in, DATA_W, signed product from the external multiplier; valid one cycle after the addresses that produced it.
- layer, out, 1, 0 = input RAM feeds the multiplier, 1 = hidden RAM feeds it.
- in_addr, out, ADDR_W, input/hidden RAM read address.
- w_addr, out, WADDR_W, weight RAM read address.
- out_addr, out, ADDR_W, neuron index being computed and written.
- out_we, out, 1, write strobe for out_data at out_addr (hidden RAM when layer=0, result RAM when layer=1).
- out_data, out, DATA_W, neuron result.
- busy, out, 1, high whenever state is not IDLE.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, DRAIN, WRITE and DONE, with these transitions:
- IDLE -> ISSUE on start=1.
- ISSUE -> DRAIN when in_addr = N_IN-1.
- DRAIN -> WRITE unconditionally.
- WRITE -> ISSUE if further neurons remain in the run (same layer or next layer), otherwise -> DONE.
- DONE -> IDLE unconditionally.
REQ-004 N_IN SHALL be L0_IN when layer=0 and L0_OUT when layer=1; N_OUT SHALL be L0_OUT when layer=0 and L1_OUT when layer=1.
REQ-005 On IDLE->ISSUE, layer, in_addr and out_addr SHALL be loaded with 0 and the accumulator cleared.
REQ-006 In ISSUE, in_addr SHALL increment by 1 per cycle from 0 to N_IN-1.
REQ-007 w_addr SHALL be a registered output equal to BASE + out_addr*N_IN + in_addr, with BASE = 0 for layer 0 and L0_IN*L0_OUT (78) for layer 1.
REQ-008 A valid flag SHALL be registered from (state==ISSUE); on any edge where the flag is 1, the accumulator SHALL add psum, two's-complement modulo 2^DATA_W with no saturation.
REQ-009 In WRITE:
- out_we=1 for exactly one cycle.
- out_data = max(acc,0) when layer=0 (ReLU); out_data = acc unmodified when layer=1.
- The accumulator SHALL clear on the same edge, and in_addr SHALL return to 0.
REQ-010 On leaving WRITE, out_addr SHALL advance as follows:
- If out_addr < N_OUT-1: out_addr increments.
- Else, if layer=0: out_addr returns to 0 and layer becomes 1.
- Else: the FSM enters DONE.
REQ-011 Each neuron SHALL take N_IN+2 cycles; a default run SHALL be 6*15 + 3*8 = 114 cycles, plus 1 DONE cycle.
REQ-012 done SHALL be 1 only in DONE; out_we SHALL be 0 outside WRITE.
REQ-013 start SHALL be ignored in every state except IDLE; start held high SHALL launch a new run on the first IDLE cycle after DONE.
REQ-014 psum SHALL be ignored whenever the valid flag is 0.

Reset
REQ-015 rst=1 SHALL immediately, without waiting for clk, force:
- state to IDLE;
- layer, in_addr, w_addr, out_addr, accumulator and valid flag to 0;
- out_we, busy and done to 0; out_data to 0.
REQ-016 Reset asserted mid-run SHALL abort the run with no further out_we pulses; the next start after rst deasserts SHALL begin a complete run from layer 0, neuron 0.

Verification
REQ-017 Reset: assert rst asynchronously mid-ISSUE -> all outputs 0 before the next clk edge; busy=0.
REQ-018 psum=1 held, start pulsed at edge 0 -> expected response:
- Six out_we pulses with out_data=13 at out_addr 0..5, layer=0.
- Then three pulses with out_data=6 at out_addr 0..2, layer=1.
- done high exactly in cycle 115.
REQ-019 psum=0xFFFF (-1) held -> layer-0 writes all 0x0000 (ReLU); layer-1 writes all 0xFFFA.
REQ-020 Overflow: psum=0x7000 -> layer-0 accumulator wraps to 0xB000 and is written as 0x0000.
REQ-021 Address check:
- Layer 1, out_addr=2, in_addr=5 -> w_addr=95.
- Layer 0, out_addr=5, in_addr=12 -> w_addr=77.
- start pulses during busy -> no effect on the sequence.
REQ-022 rst asserted during layer-1 neuron 1, then start -> no further writes from the aborted run; the new run reproduces REQ-018 exactly.
